// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu with a
// fixed busy latency and commits the result atomically; mthi/mtlo write directly.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        start,
  input  logic        mt,
  input  logic [2:0]  MDU_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(32'd0);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic [31:0] temp_hi_r, temp_hi_s, temp_lo_r, temp_lo_s;
  logic [31:0] hi_r, hi_s, lo_r, lo_s;
  logic        div_zero_r, div_zero_s;
  logic        busy_r, busy_s;
  logic        md_op_s;
  logic [63:0] result_s;

  // Result as {HI, LO}; signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
  function automatic logic [63:0] md_result(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] ea, eb;
    logic [31:0] ua, ub, q, r;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    ua = a[31] ? (32'd0 - a) : a;
    ub = b[31] ? (32'd0 - b) : b;
    if (ub != 32'd0) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      q = 32'd0;
      r = 32'd0;
    end
    case (op)
      3'b011:  md_result = ea * eb;
      3'b010:  md_result = {32'd0, a} * {32'd0, b};
      3'b101:  md_result = {(a[31] ? (32'd0 - r) : r), ((a[31] ^ b[31]) ? (32'd0 - q) : q)};
      3'b100:  md_result = (b != 32'd0) ? {a % b, a / b} : 64'd0;
      default: md_result = 64'd0;
    endcase
  endfunction

  assign md_op_s  = (MDU_op == 3'b011) || (MDU_op == 3'b010) ||
                    (MDU_op == 3'b101) || (MDU_op == 3'b100);
  assign result_s = md_result(MDU_op, rs_val, rt_val);

  // Next-state, counter, result latch and HI/LO update logic.
  always_comb begin
    state_s    = state_r;
    count_s    = count_r;
    busy_s     = busy_r;
    temp_hi_s  = temp_hi_r;
    temp_lo_s  = temp_lo_r;
    div_zero_s = div_zero_r;
    hi_s       = hi_r;
    lo_s       = lo_r;
    case (state_r)
      IDLE: begin
        if (!req && start) begin
          if (md_op_s) begin
            state_s    = BUSY;
            busy_s     = 1'b1;
            count_s    = MDU_op[2] ? DIV_LOAD : MULT_LOAD;
            temp_hi_s  = result_s[63:32];
            temp_lo_s  = result_s[31:0];
            div_zero_s = MDU_op[2] && (rt_val == 32'd0);
          end else begin
            state_s = IDLE;
          end
        end else if (!req && mt) begin
          if (MDU_op == 3'b001) begin
            hi_s = rs_val;
          end else if (MDU_op == 3'b000) begin
            lo_s = rs_val;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // A zero divisor still burns the full latency but leaves HI/LO untouched.
        if (count_r == CNT_ONE) begin
          state_s = IDLE;
          busy_s  = 1'b0;
          count_s = CNT_ZERO;
          if (!div_zero_r) begin
            hi_s = temp_hi_r;
            lo_s = temp_lo_r;
          end else begin
            hi_s = hi_r;
            lo_s = lo_r;
          end
        end else begin
          count_s = count_r - CNT_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
        count_s = CNT_ZERO;
      end
    endcase
  end

  // State and architectural register update with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= CNT_ZERO;
      busy_r     <= 1'b0;
      temp_hi_r  <= 32'd0;
      temp_lo_r  <= 32'd0;
      div_zero_r <= 1'b0;
      hi_r       <= 32'd0;
      lo_r       <= 32'd0;
    end else begin
      state_r    <= state_s;
      count_r    <= count_s;
      busy_r     <= busy_s;
      temp_hi_r  <= temp_hi_s;
      temp_lo_r  <= temp_lo_s;
      div_zero_r <= div_zero_s;
      hi_r       <= hi_s;
      lo_r       <= lo_s;
    end
  end

  assign busy = busy_r;
  assign HI   = hi_r;
  assign LO   = lo_r;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed spec vectors plus randomized traffic
// checked against an arithmetic reference model of HI/LO.
module tb_mdu_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        start = 1'b0;
  logic        mt = 1'b0;
  logic [2:0]  MDU_op = 3'b000;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .start(start), .mt(mt), .MDU_op(MDU_op),
    .rs_val(rs_val), .rt_val(rt_val), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  function automatic logic is_md(input logic [2:0] op);
    return (op == 3'b011) || (op == 3'b010) || (op == 3'b101) || (op == 3'b100);
  endfunction

  // Returns {commit, hi, lo} from plain integer arithmetic.
  function automatic logic [64:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int sa, sb;
    longint p;
    logic [63:0] u;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (op)
      3'b011: begin
        p = longint'(sa) * longint'(sb);
        u = p;
        return {1'b1, u};
      end
      3'b010: begin
        u = 64'(a) * 64'(b);
        return {1'b1, u};
      end
      3'b101: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {1'b1, 32'd0, 32'h80000000};
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r, q};
      end
      3'b100: begin
        if (b == 32'd0) return {1'b0, 64'd0};
        return {1'b1, a % b, a / b};
      end
      default: return {1'b0, 64'd0};
    endcase
  endfunction

  task automatic apply_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic rq, input logic noise, input string tag);
    logic [64:0] r;
    logic [31:0] old_hi, old_lo;
    int n;
    r = ref_md(op, a, b);
    old_hi = exp_hi;
    old_lo = exp_lo;
    MDU_op = op; rs_val = a; rt_val = b; start = 1'b1; req = rq;
    @(posedge clk); #1;
    start = 1'b0; req = 1'b0;
    if (rq || !is_md(op)) begin
      checks++;
      if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
        errors++;
        $display("FAIL %s_ignored: busy=%b HI=%h LO=%h, expected busy=0 HI=%h LO=%h",
                 tag, busy, HI, LO, exp_hi, exp_lo);
      end
      return;
    end
    n = op[2] ? DIV_N : MULT_N;
    for (int k = 1; k <= n; k++) begin
      checks++;
      if (busy !== 1'b1 || HI !== old_hi || LO !== old_lo) begin
        errors++;
        $display("FAIL %s_busy%0d: busy=%b HI=%h LO=%h, expected busy=1 HI=%h LO=%h",
                 tag, k, busy, HI, LO, old_hi, old_lo);
      end
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        mt = 1'($urandom_range(0, 1));
        req = 1'($urandom_range(0, 1));
        MDU_op = 3'($urandom);
        rs_val = $urandom;
        rt_val = $urandom;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; mt = 1'b0; req = 1'b0;
    if (r[64]) begin
      exp_hi = r[63:32];
      exp_lo = r[31:0];
    end
    checks++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++;
      $display("FAIL %s_commit: busy=%b HI=%h LO=%h, expected busy=0 HI=%h LO=%h",
               tag, busy, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic apply_mt(input logic [2:0] op, input logic [31:0] a, input logic rq,
                          input string tag);
    MDU_op = op; rs_val = a; mt = 1'b1; req = rq;
    @(posedge clk); #1;
    mt = 1'b0; req = 1'b0;
    if (!rq && op == 3'b001) exp_hi = a;
    if (!rq && op == 3'b000) exp_lo = a;
    checks++;
    if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
      errors++;
      $display("FAIL %s: busy=%b HI=%h LO=%h, expected busy=0 HI=%h LO=%h",
               tag, busy, HI, LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b HI=%h LO=%h, expected 0/0/0", busy, HI, LO);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b HI=%h LO=%h, expected 0/0/0", busy, HI, LO);
    end
  endtask

  task automatic test_directed;
    apply_md(3'b011, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0, "mult_neg");
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFF1) begin
      errors++;
      $display("FAIL mult_vec: HI=%h LO=%h, expected FFFFFFFF FFFFFFF1", HI, LO);
    end
    apply_md(3'b010, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0, "multu");
    checks++;
    if (HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
      errors++;
      $display("FAIL multu_vec: HI=%h LO=%h, expected 00000001 FFFFFFFE", HI, LO);
    end
    apply_md(3'b101, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, "div_neg");
    checks++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL div_vec: HI=%h LO=%h, expected FFFFFFFF FFFFFFFD", HI, LO);
    end
    apply_mt(3'b001, 32'h11, 1'b0, "mthi_11");
    apply_mt(3'b000, 32'h22, 1'b0, "mtlo_22");
    apply_md(3'b100, 32'd7, 32'd0, 1'b0, 1'b0, "divu_zero");
    checks++;
    if (HI !== 32'h11 || LO !== 32'h22) begin
      errors++;
      $display("FAIL divu_zero_vec: HI=%h LO=%h, expected 00000011 00000022", HI, LO);
    end
    apply_md(3'b101, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, "div_ovf");
    checks++;
    if (HI !== 32'd0 || LO !== 32'h80000000) begin
      errors++;
      $display("FAIL div_ovf_vec: HI=%h LO=%h, expected 00000000 80000000", HI, LO);
    end
    apply_md(3'b101, 32'd7, 32'd0, 1'b0, 1'b0, "div_zero");
  endtask

  task automatic test_req_and_illegal;
    apply_mt(3'b001, 32'hABCD0000, 1'b1, "mthi_req");
    apply_mt(3'b001, 32'hABCD0000, 1'b0, "mthi");
    apply_md(3'b011, 32'd3, 32'd4, 1'b1, 1'b0, "mult_req");
    apply_md(3'b111, 32'd3, 32'd4, 1'b0, 1'b0, "start_badop");
    apply_mt(3'b110, 32'h5555AAAA, 1'b0, "mt_badop");
    apply_md(3'b010, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, "multu_noise");
    apply_md(3'b101, 32'h7FFFFFFF, 32'hFFFFFFF0, 1'b0, 1'b1, "div_noise");
  endtask

  task automatic test_reset_mid;
    MDU_op = 3'b100; rs_val = 32'd100; rt_val = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: busy=%b, expected 1", busy);
    end
    reset = 1'b1;
    #1;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    checks++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b HI=%h LO=%h, expected 0/0/0", busy, HI, LO);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    apply_md(3'b011, 32'hFFFF0000, 32'h00010000, 1'b0, 1'b0, "mult_after_reset");
  endtask

  task automatic test_back_to_back;
    apply_md(3'b100, 32'hDEADBEEF, 32'd16, 1'b0, 1'b0, "b2b_divu");
    apply_md(3'b011, 32'h80000000, 32'h80000000, 1'b0, 1'b0, "b2b_mult");
    apply_mt(3'b000, 32'hCAFEF00D, 1'b0, "b2b_mtlo");
    apply_md(3'b101, 32'h00000064, 32'hFFFFFFF9, 1'b0, 1'b0, "b2b_div");
  endtask

  task automatic test_random;
    logic [2:0] ops [6];
    logic [31:0] specials [5];
    logic [31:0] a, b;
    logic [2:0] op;
    ops = '{3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    specials = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(0, 5)];
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
      if (op == 3'b011 || op == 3'b010 || op == 3'b101 || op == 3'b100)
        apply_md(op, a, b, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rand_md");
      else
        apply_mt(op, a, 1'($urandom_range(0, 5) == 0), "rand_mt");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_req_and_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
